word_arith_checker: RTL and testbench

Receive-side checker for the 8-bit word-arithmetic producer stream. Each accepted word x is used to recompute the producer's next-state function f(x) = ((((x+1)^2 · (x−2)) mod 256) / 3) mod (x+1), with every intermediate truncated to 8 bits. The next accepted word is compared against that prediction. The checker sits after a stalling adapter on the producer's output and uses multi-cycle iterative division in place of the producer's single-cycle combinational `/` and `%`.

---
 rtl/word_arith_pkg.sv | 32 +++
 rtl/word_seq_divider.sv | 63 ++++++
 rtl/word_arith_checker.sv | 128 ++++++++++++
 tb/tb_word_arith_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_arith_pkg.sv
// Shared types and constants for the word-arithmetic stream checker.
// next_state_ref is a plain behavioural model of the producer's next-state function.
package word_arith_pkg;

    localparam int WORD_W     = 8;
    localparam int DIV_CONST  = 3;
    localparam int DIV_CYCLES = 8;

    typedef enum logic [2:0] {
        SEED,
        MUL,
        DIV,
        MOD,
        WAIT
    } state_t;

    // Returns {valid, value}; valid is low when the modulus x+1 wraps to zero.
    function automatic logic [WORD_W:0] next_state_ref(input logic [WORD_W-1:0] x);
        logic [WORD_W-1:0] x_inc;
        logic [WORD_W-1:0] prod;
        logic [WORD_W-1:0] quo;
        x_inc = x + 8'd1;
        prod  = 8'(x_inc * x_inc);
        prod  = 8'(prod * (x - 8'd2));
        quo   = prod / 8'(DIV_CONST);
        if (x_inc == 8'd0) begin
            return '0;
        end
        return {1'b1, quo % x_inc};
    endfunction

endpackage

// File: rtl/word_seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle MSB first; done pulses on the DIV_CYCLES-th cycle counted from start.
// No backpressure: operands are sampled on start, results are valid only while done is high.
module word_seq_divider
    import word_arith_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] dividend,
    input  logic [WORD_W-1:0] divisor,
    output logic              done,
    output logic [WORD_W-1:0] quotient,
    output logic [WORD_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

    logic              busy;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     idx;
    logic [WORD_W-1:0] rem;
    logic [WORD_W-1:0] quo;
    logic [WORD_W-1:0] dvs;
    logic [WORD_W-1:0] rem_src;
    logic [WORD_W-1:0] quo_src;
    logic [WORD_W-1:0] dvs_src;
    logic [WORD_W:0]   trial;
    logic              ge;

    // The start cycle already performs the first step straight from the input operands.
    always_comb begin
        rem_src   = start ? '0 : rem;
        quo_src   = start ? dividend : quo;
        dvs_src   = start ? divisor : dvs;
        idx       = start ? '0 : cnt;
        trial     = {rem_src, quo_src[WORD_W-1]};
        ge        = (trial >= {1'b0, dvs_src});
        remainder = ge ? WORD_W'(trial - {1'b0, dvs_src}) : trial[WORD_W-1:0];
        quotient  = {quo_src[WORD_W-2:0], ge};
    end

    assign done        = (start || busy) && (idx == LAST);
    assign div_by_zero = (dvs_src == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
        end else if (start || busy) begin
            rem  <= remainder;
            quo  <= quotient;
            dvs  <= dvs_src;
            cnt  <= idx + 1'b1;
            busy <= !done;
        end
    end

endmodule

// File: rtl/word_arith_checker.sv
// Predicts each next stream word from the previous one and counts matches/mismatches; 18 cycles per accepted word.
// in_ready only in SEED/WAIT; in_valid elsewhere is ignored and the upstream adapter must hold its word.
module word_arith_checker
    import word_arith_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] exp_data,
    output logic              exp_valid,
    output logic              mismatch,
    output logic              err,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic              xfer;
    logic              launch;
    logic [WORD_W-1:0] prev;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] q;
    logic [WORD_W-1:0] x_inc;
    logic [WORD_W-1:0] x_dec;
    logic [WORD_W-1:0] sq;
    logic [WORD_W-1:0] mul_p;
    logic [WORD_W-1:0] div_dividend;
    logic [WORD_W-1:0] div_divisor;
    logic              div_done;
    logic [WORD_W-1:0] div_quo;
    logic [WORD_W-1:0] div_rem;
    logic              div_dbz;

    assign in_ready = (state == SEED) || (state == WAIT);
    assign xfer     = in_valid && in_ready;
    assign mismatch = (state == WAIT) && in_valid && exp_valid && (in_data != exp_data);

    // Every product is deliberately truncated to the word width, matching the producer.
    assign x_inc = prev + 8'd1;
    assign x_dec = prev - 8'd2;
    assign sq    = x_inc * x_inc;
    assign mul_p = sq * x_dec;

    assign div_dividend = (state == MOD) ? q : p;
    assign div_divisor  = (state == MOD) ? d : WORD_W'(DIV_CONST);

    word_seq_divider u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (launch),
        .dividend    (div_dividend),
        .divisor     (div_divisor),
        .done        (div_done),
        .quotient    (div_quo),
        .remainder   (div_rem),
        .div_by_zero (div_dbz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEED:    if (in_valid) state_nxt = MUL;
            MUL:     state_nxt = DIV;
            DIV:     if (div_done) state_nxt = MOD;
            MOD:     if (div_done) state_nxt = WAIT;
            WAIT:    if (in_valid) state_nxt = MUL;
            default: state_nxt = SEED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= '0;
            p         <= '0;
            d         <= '0;
            q         <= '0;
            launch    <= 1'b0;
            exp_data  <= '0;
            exp_valid <= 1'b0;
            err       <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            // launch marks the first cycle of each divider pass
            launch <= (state == MUL) || ((state == DIV) && div_done);
            case (state)
                SEED: if (xfer) prev <= in_data;
                MUL: begin
                    p <= mul_p;
                    d <= x_inc;
                end
                DIV: if (div_done) q <= div_quo;
                MOD: if (div_done) begin
                    exp_valid <= !div_dbz;
                    exp_data  <= div_dbz ? '0 : div_rem;
                end
                WAIT: if (xfer) begin
                    if (exp_valid) begin
                        if (mismatch) begin
                            err <= 1'b1;
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                        end else if (match_cnt != '1) begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                    prev      <= in_data;
                    exp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_word_arith_checker.sv
// Directed bench for word_arith_checker, run with 4-bit counters so saturation is reachable.
module tb_word_arith_checker;
    import word_arith_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       mismatch;
    logic       err;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    word_arith_checker #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_data  (exp_data),
        .exp_valid (exp_valid),
        .mismatch  (mismatch),
        .err       (err),
        .match_cnt (match_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge with in_ready high.
    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 16'(in_ready), 16'd1);
    endtask

    // One transfer; mm is the mismatch output seen during the transfer cycle.
    task automatic send(input logic [7:0] w, output logic mm);
        int n;
        wait_ready(n);
        in_data  = w;
        in_valid = 1'b1;
        #1;
        mm = mismatch;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic mm;
        int   n;
        int   xfers;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check("rst_in_ready",  16'(in_ready),  16'd1);
        check("rst_exp_valid", 16'(exp_valid), 16'd0);
        check("rst_exp_data",  16'(exp_data),  16'd0);
        check("rst_mismatch",  16'(mismatch),  16'd0);
        check("rst_err",       16'(err),       16'd0);
        check("rst_match_cnt", 16'(match_cnt), 16'd0);
        check("rst_miss_cnt",  16'(miss_cnt),  16'd0);
        @(negedge clk);
        rst = 1'b0;

        check("ref_f7",   16'(next_state_ref(8'd7)),   16'h105);
        check("ref_f42",  16'(next_state_ref(8'd42)),  16'h122);
        check("ref_f255", 16'(next_state_ref(8'd255)), 16'h000);

        // Zeros back to back, with 18-cycle turnaround
        send(8'd0, mm);
        check("z_seed_mm", 16'(mm), 16'd0);
        check("z_busy", 16'(in_ready), 16'd0);
        wait_ready(n);
        check("z_latency1", 16'(n), 16'd17);
        check("z_exp_valid", 16'(exp_valid), 16'd1);
        check("z_exp_data", 16'(exp_data), 16'd0);
        send(8'd0, mm);
        check("z_mm1", 16'(mm), 16'd0);
        wait_ready(n);
        check("z_latency2", 16'(n), 16'd17);
        send(8'd0, mm);
        check("z_mm2", 16'(mm), 16'd0);
        check("z_match", 16'(match_cnt), 16'd2);
        check("z_miss", 16'(miss_cnt), 16'd0);

        // 7 -> 5 -> 0
        do_reset();
        send(8'd7, mm);
        wait_ready(n);
        check("s7_exp_data", 16'(exp_data), 16'd5);
        check("s7_exp_valid", 16'(exp_valid), 16'd1);
        send(8'd5, mm);
        check("s7_mm5", 16'(mm), 16'd0);
        check("s7_exp_valid_cleared", 16'(exp_valid), 16'd0);
        wait_ready(n);
        check("s5_exp_data", 16'(exp_data), 16'd0);
        send(8'd0, mm);
        check("s5_mm0", 16'(mm), 16'd0);
        check("s7_match", 16'(match_cnt), 16'd2);
        check("s7_miss", 16'(miss_cnt), 16'd0);

        // 3 -> 2 is a mismatch, then matching traffic
        do_reset();
        send(8'd3, mm);
        wait_ready(n);
        check("s3_exp_data", 16'(exp_data), 16'd1);
        send(8'd2, mm);
        check("s3_mm_pulse", 16'(mm), 16'd1);
        check("s3_mm_after", 16'(mismatch), 16'd0);
        check("s3_err", 16'(err), 16'd1);
        check("s3_miss", 16'(miss_cnt), 16'd1);
        wait_ready(n);
        check("s2_exp_data", 16'(exp_data), 16'd0);
        send(8'd0, mm);
        check("s2_mm", 16'(mm), 16'd0);
        check("s2_err_sticky", 16'(err), 16'd1);
        check("s2_miss_kept", 16'(miss_cnt), 16'd1);
        check("s2_match", 16'(match_cnt), 16'd1);

        // 255 has no defined successor
        do_reset();
        send(8'd255, mm);
        wait_ready(n);
        check("s255_exp_valid", 16'(exp_valid), 16'd0);
        check("s255_exp_data", 16'(exp_data), 16'd0);
        send(8'd42, mm);
        check("s42_mm", 16'(mm), 16'd0);
        check("s42_match", 16'(match_cnt), 16'd0);
        check("s42_miss", 16'(miss_cnt), 16'd0);
        check("s42_err", 16'(err), 16'd0);
        wait_ready(n);
        check("s42_exp_valid", 16'(exp_valid), 16'd1);
        check("s42_exp_data", 16'(exp_data), 16'd34);

        // in_valid held high; only the words present while in_ready is high are consumed
        do_reset();
        xfers = 0;
        for (int k = 0; k < 54; k++) begin
            in_valid = 1'b1;
            in_data  = (k == 0) ? 8'd4 : (k == 18) ? 8'd1 : (k == 36) ? 8'd0 : 8'(8'hC0 + k);
            #1;
            if (in_ready) xfers++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("hold_xfers", 16'(xfers), 16'd3);
        check("hold_match", 16'(match_cnt), 16'd2);
        check("hold_miss", 16'(miss_cnt), 16'd0);
        check("hold_exp_data", 16'(exp_data), 16'd0);

        // Asynchronous reset in the middle of a divide
        do_reset();
        send(8'd4, mm);
        wait_ready(n);
        send(8'd1, mm);
        repeat (3) @(negedge clk);
        check("mid_busy", 16'(in_ready), 16'd0);
        check("mid_match", 16'(match_cnt), 16'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 16'(in_ready), 16'd1);
        check("mid_rst_match", 16'(match_cnt), 16'd0);
        check("mid_rst_exp_data", 16'(exp_data), 16'd0);
        check("mid_rst_exp_valid", 16'(exp_valid), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'd3, mm);
        check("mid_reseed_mm", 16'(mm), 16'd0);
        check("mid_reseed_match", 16'(match_cnt), 16'd0);
        check("mid_reseed_miss", 16'(miss_cnt), 16'd0);
        wait_ready(n);
        check("mid_reseed_exp", 16'(exp_data), 16'd1);

        // Saturation of both counters
        do_reset();
        send(8'd0, mm);
        for (int i = 0; i < 15; i++) send(8'd0, mm);
        check("sat_match_full", 16'(match_cnt), 16'd15);
        for (int i = 0; i < 2; i++) send(8'd0, mm);
        check("sat_match_hold", 16'(match_cnt), 16'd15);
        for (int i = 0; i < 17; i++) send(8'd1, mm);
        check("sat_miss_hold", 16'(miss_cnt), 16'd15);
        check("sat_match_kept", 16'(match_cnt), 16'd15);
        check("sat_err", 16'(err), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
